muldiv_unit: RTL
================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width (even, >=8).
REQ-002 SHALL have parameter TAGW, default 5, width of destination-register tag carried with each operation.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port in_valid  input  1  operation request present.
REQ-006 SHALL have port in_ready  output  1  unit can accept a request this cycle.
REQ-007 SHALL have port funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 SHALL have port srcA  input  XLEN  rs1 operand (multiplicand/dividend).
REQ-009 SHALL have port srcB  input  XLEN  rs2 operand (multiplier/divisor).
REQ-010 SHALL have port in_tag  input  TAGW  tag captured with request.
REQ-011 SHALL have port flush  input  1  abandon any in-flight or pending operation.
REQ-012 SHALL have port out_valid  output  1  result available.
REQ-013 SHALL have port out_ready  input  1  consumer accepts result.
REQ-014 SHALL have port result  output  XLEN  operation result.
REQ-015 SHALL have port out_tag  output  TAGW  tag of the operation in result.
REQ-016 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, CALC, DONE; in_ready = (state==IDLE) and not flush.
REQ-018 Accept SHALL occur on an edge with in_valid && in_ready; operands, funct3, in_tag latched at that edge.
REQ-019 On accept of a normal op, SHALL enter CALC; CALC SHALL last exactly XLEN cycles (one shift-add or restoring-subtract step per cycle, iteration counter 0..XLEN-1).
REQ-020 After the final CALC cycle SHALL enter DONE; out_valid SHALL first be high XLEN+1 cycles after the accept edge.
REQ-021 Multiply SHALL form the full 2*XLEN product; MUL returns low XLEN bits, MULH/MULHSU/MULHU the high XLEN bits with signed*signed, signed*unsigned, unsigned*unsigned operand interpretation.
REQ-022 Signed divide SHALL operate on magnitudes and fix signs: quotient negative iff operand signs differ, remainder takes dividend's sign; quotient truncates toward zero.
REQ-023 Divide-by-zero SHALL bypass CALC (IDLE -> DONE): DIV/DIVU result all ones, REM/REMU result = srcA; out_valid high 1 cycle after accept.
REQ-024 Signed overflow (srcA = most-negative, srcB = all ones, DIV/REM) SHALL bypass CALC: DIV result = srcA, REM result = 0; out_valid 1 cycle after accept.
REQ-025 In DONE, out_valid SHALL stay high with result and out_tag stable until an edge with out_ready high, then return to IDLE; in_ready stays low throughout DONE.
REQ-026 flush SHALL take priority over every other event: on an edge with flush high the unit SHALL enter IDLE, drop any in-flight or undelivered result, and accept nothing that cycle.
REQ-027 out_valid SHALL be low in IDLE and CALC; result/out_tag are don't-care when out_valid is low.

Reset
REQ-028 On an edge with rst high, SHALL enter IDLE, clear the iteration counter, drive out_valid=0, busy=0, result=0, out_tag=0; in_ready=1 the cycle after rst deasserts.
REQ-029 rst asserted during CALC or DONE SHALL discard the operation; no out_valid pulse follows.

Verification
REQ-030 MUL srcA=5, srcB=6, accept at edge k -> out_valid at edge k+33, result=0x0000001E, out_tag echoes in_tag.
REQ-031 MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0x00000002 -> 0xFFFFFFFF.
REQ-032 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-033 DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, both with out_valid 1 cycle after accept; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0, 1 cycle.
REQ-034 out_ready held low 5 cycles in DONE -> result/out_tag unchanged, in_ready=0, busy=1; out_ready=1 -> IDLE next edge.
REQ-035 flush at CALC iteration 10, and separately rst mid-CALC -> no out_valid ever for that op; in_ready=1 next cycle; following MUL 3*4 returns 12.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
//
// Multiplies with one shift-add step per cycle and divides with one
// restoring-subtract step per cycle. Signed operations run on operand
// magnitudes, and the signs are fixed when the result is written.
// Divide-by-zero and signed overflow skip the iterative phase and are
// resolved directly at accept.
//
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   in_valid       request present; accepted when in_ready is also high
//   in_ready       unit idle and not being flushed
//   funct3         RV32M op select (MUL..REMU)
//   srcA, srcB     rs1 / rs2 operands
//   in_tag         destination tag carried with the op
//   flush          drop any in-flight or undelivered op
//   out_valid      result held until out_ready is high
//   out_ready      consumer accepts result
//   result         operation result
//   out_tag        tag of the op in result
//   busy           unit not idle
module muldiv_unit #(
  parameter int XLEN = 32,
  parameter int TAGW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  input  logic [TAGW-1:0] in_tag,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [TAGW-1:0] out_tag,
  output logic            busy
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          r_state;
  state_t          w_state_next;

  logic [CW-1:0]   r_cnt;
  logic [XLEN-1:0] r_hi;      // product high half / partial remainder
  logic [XLEN-1:0] r_lo;      // multiplier being shifted out / dividend becoming quotient
  logic [XLEN-1:0] r_b;       // multiplicand or divisor magnitude
  logic [2:0]      r_f3;
  logic            r_neg_p;   // negate product, or quotient
  logic            r_neg_r;   // negate remainder
  logic [XLEN-1:0] r_result;
  logic [TAGW-1:0] r_tag;

  // Request decode
  logic            w_accept;
  logic            w_is_div;
  logic            w_a_signed;
  logic            w_b_signed;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic            w_div_zero;
  logic            w_ovf;
  logic            w_bypass;
  logic [XLEN-1:0] w_bypass_res;

  assign w_accept   = in_valid && in_ready;
  assign w_is_div   = funct3[2];
  // Signed rs1: MULH, MULHSU, DIV, REM. Signed rs2: MULH, DIV, REM.
  assign w_a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                      (funct3 == 3'b100) || (funct3 == 3'b110);
  assign w_b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) ||
                      (funct3 == 3'b110);
  assign w_a_neg    = w_a_signed && srcA[XLEN-1];
  assign w_b_neg    = w_b_signed && srcB[XLEN-1];
  // The most-negative value maps onto itself, which is also its correct
  // unsigned magnitude.
  assign w_a_mag    = w_a_neg ? -srcA : srcA;
  assign w_b_mag    = w_b_neg ? -srcB : srcB;
  assign w_div_zero = (srcB == '0);
  assign w_ovf      = !funct3[0] && (srcA == {1'b1, {(XLEN-1){1'b0}}}) &&
                      (srcB == '1);
  assign w_bypass   = w_is_div && (w_div_zero || w_ovf);
  // funct3[1] selects the remainder flavour of divide
  always_comb begin
    w_bypass_res = '0;
    if (w_div_zero) begin
      w_bypass_res = funct3[1] ? srcA : '1;
    end else begin
      w_bypass_res = funct3[1] ? '0 : srcA;
    end
  end

  // One multiply step: add multiplicand into the high half when the
  // current multiplier bit is set, then shift the whole pair right.
  logic [XLEN:0]   w_sum;
  logic [XLEN-1:0] w_mul_hi;
  logic [XLEN-1:0] w_mul_lo;

  assign w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  assign w_mul_hi = w_sum[XLEN:1];
  assign w_mul_lo = {w_sum[0], r_lo[XLEN-1:1]};

  // One restoring divide step. The partial remainder is always below the
  // divisor, so the shifted value is below twice the divisor and the sign
  // of the XLEN+1 bit difference tells whether the subtraction fits.
  logic [XLEN:0]   w_rem_sh;
  logic [XLEN:0]   w_diff;
  logic            w_ge;
  logic [XLEN-1:0] w_div_hi;
  logic [XLEN-1:0] w_div_lo;

  assign w_rem_sh = {r_hi, r_lo[XLEN-1]};
  assign w_diff   = w_rem_sh - {1'b0, r_b};
  assign w_ge     = !w_diff[XLEN];
  assign w_div_hi = w_ge ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
  assign w_div_lo = {r_lo[XLEN-2:0], w_ge};

  logic [XLEN-1:0] w_hi_nx;
  logic [XLEN-1:0] w_lo_nx;

  assign w_hi_nx = r_f3[2] ? w_div_hi : w_mul_hi;
  assign w_lo_nx = r_f3[2] ? w_div_lo : w_mul_lo;

  // Sign fix-up applied to the values produced by the last step
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_final;

  assign w_prod     = {w_hi_nx, w_lo_nx};
  assign w_prod_fix = r_neg_p ? -w_prod : w_prod;
  assign w_quo      = r_neg_p ? -w_lo_nx : w_lo_nx;
  assign w_rem      = r_neg_r ? -w_hi_nx : w_hi_nx;

  always_comb begin
    w_final = '0;
    if (r_f3[2]) begin
      w_final = r_f3[1] ? w_rem : w_quo;
    end else if (r_f3[1:0] == 2'b00) begin
      w_final = w_prod_fix[XLEN-1:0];
    end else begin
      w_final = w_prod_fix[2*XLEN-1:XLEN];
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state and status outputs
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = !flush;
        if (w_accept) begin
          w_state_next = w_bypass ? DONE : CALC;
        end
      end
      CALC: begin
        busy = 1'b1;
        if (r_cnt == LAST) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
    if (flush) begin
      w_state_next = IDLE;
    end
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_f3     <= '0;
      r_neg_p  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
      r_tag    <= '0;
    end else if (flush) begin
      r_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_cnt   <= '0;
            r_tag   <= in_tag;
            r_f3    <= funct3;
            r_hi    <= '0;
            r_neg_p <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            if (w_is_div) begin
              r_lo <= w_a_mag;
              r_b  <= w_b_mag;
            end else begin
              r_lo <= w_b_mag;
              r_b  <= w_a_mag;
            end
            if (w_bypass) begin
              r_result <= w_bypass_res;
            end
          end
        end
        CALC: begin
          r_hi <= w_hi_nx;
          r_lo <= w_lo_nx;
          if (r_cnt == LAST) begin
            r_cnt    <= '0;
            r_result <= w_final;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign result  = r_result;
  assign out_tag = r_tag;

endmodule
